// File: rtl/rifl_rx_lane_buffer_if.sv
// AXI-Stream beat bundle shared by the write and read sides of the RIFL RX lane buffer.
// A beat transfers on a rising clk edge where tvalid && tready; tdata/tkeep/tlast are qualified by tvalid.
interface rifl_rx_lane_buffer_if #(
  parameter int DWIDTH = 240
);
  logic [DWIDTH-1:0]   tdata;
  logic [DWIDTH/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/rifl_rx_lane_buffer.sv
// RIFL RX lane buffer: show-ahead FIFO with hysteretic pause request and sticky overflow.
// Optional macro RIFL_RX_BUF_DROP_CNT_EN adds a saturating 16-bit dropped-beat counter.
module rifl_rx_lane_buffer #(
  parameter int DWIDTH        = 240,
  parameter int DEPTH         = 512,
  parameter int PAUSE_ON_VAL  = 2 * DEPTH / 3,
  parameter int PAUSE_OFF_VAL = DEPTH / 3
) (
  input  logic                      clk,
  input  logic                      rst,
  rifl_rx_lane_buffer_if.slave      s_axis,
  rifl_rx_lane_buffer_if.master     m_axis,
  output logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      pause_req,
  output logic                      overflow,
  output logic [15:0]               drop_cnt,
  output logic                      dbg_paused
);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = DWIDTH / 8;
  localparam int EW = DWIDTH + KW + 1;
  localparam logic [AW:0] ON_CNT  = (AW + 1)'(PAUSE_ON_VAL);
  localparam logic [AW:0] OFF_CNT = (AW + 1)'(PAUSE_OFF_VAL);

  generate
    if (PAUSE_OFF_VAL >= PAUSE_ON_VAL || PAUSE_ON_VAL > DEPTH) begin : g_bad_pause
      $error("rifl_rx_lane_buffer: need PAUSE_OFF_VAL < PAUSE_ON_VAL <= DEPTH");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rifl_rx_lane_buffer: DEPTH must be a power of two >= 4");
    end
    if (DWIDTH % 8 != 0) begin : g_bad_width
      $error("rifl_rx_lane_buffer: DWIDTH must be a multiple of 8");
    end
  endgenerate

  typedef enum logic {RUN = 1'b0, PAUSED = 1'b1} state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_e        state_q, state_d;
  logic          overflow_q, overflow_d;
  logic          full, empty, wr_en, rd_en, drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    wr_en    = s_axis.tvalid && !full;
    drop     = s_axis.tvalid && full;
    rd_en    = !empty && m_axis.tready;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
    overflow_d = overflow_q || drop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (fifo_cnt >= ON_CNT)  state_d = PAUSED;
      PAUSED:  if (fifo_cnt <= OFF_CNT) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= RUN;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {s_axis.tdata, s_axis.tkeep, s_axis.tlast};
  end

  // Read data is presented combinationally from the head entry (show-ahead).
  assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast} = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis.tvalid = !empty;
  assign s_axis.tready = !full;
  assign fifo_cnt      = wr_ptr_q - rd_ptr_q;
  assign pause_req     = (state_q == PAUSED);
  assign dbg_paused    = (state_q == PAUSED);
  assign overflow      = overflow_q;

`ifdef RIFL_RX_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= 16'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_rifl_rx_lane_buffer.sv
// Directed bench for rifl_rx_lane_buffer (DWIDTH=240, DEPTH=16, PAUSE_ON_VAL=10, PAUSE_OFF_VAL=5).
module tb_rifl_rx_lane_buffer;
  localparam int DWIDTH = 240;
  localparam int DEPTH  = 16;
  localparam int KW     = DWIDTH / 8;
  localparam int W      = DWIDTH + KW + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  fifo_cnt;
  logic        pause_req, overflow, dbg_paused;
  logic [15:0] drop_cnt;

  rifl_rx_lane_buffer_if #(.DWIDTH(DWIDTH)) s_if ();
  rifl_rx_lane_buffer_if #(.DWIDTH(DWIDTH)) m_if ();

  rifl_rx_lane_buffer #(
    .DWIDTH(DWIDTH), .DEPTH(DEPTH), .PAUSE_ON_VAL(10), .PAUSE_OFF_VAL(5)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .fifo_cnt(fifo_cnt), .pause_req(pause_req), .overflow(overflow),
    .drop_cnt(drop_cnt), .dbg_paused(dbg_paused)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  int sent;
  bit wv;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic [DWIDTH-1:0] d);
    return {d, d[KW-1:0] ^ 30'h2AAAAAAA, d[0]};
  endfunction

  // driver: one clock cycle with optional write and optional read, model updated alongside
  task automatic cycle(input bit wr, input logic [W-1:0] b, input bit rd);
    bit acc;
    s_if.tvalid = wr;
    {s_if.tdata, s_if.tkeep, s_if.tlast} = b;
    m_if.tready = rd;
    acc = wr && (exp_q.size() < DEPTH);
    if (wr && !acc) exp_drops++;
    if (rd && exp_q.size() != 0)
      check("rd_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, exp_q.pop_front());
    if (acc) exp_q.push_back(b);
    @(posedge clk); #1;
    check("fifo_cnt", W'(fifo_cnt), W'(exp_q.size()));
    check("m_tvalid", W'(m_if.tvalid), W'(exp_q.size() != 0));
    check("s_tready", W'(s_if.tready), W'(exp_q.size() < DEPTH));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b1);
    check("drained", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("rst_cnt",      W'(fifo_cnt),    W'(0));
    check("rst_m_tvalid", W'(m_if.tvalid), W'(0));
    check("rst_s_tready", W'(s_if.tready), W'(1));
    check("rst_pause",    W'(pause_req),   W'(0));
    check("rst_state",    W'(dbg_paused),  W'(0));
    check("rst_overflow", W'(overflow),    W'(0));
    check("rst_drop_cnt", W'(drop_cnt),    W'(0));

    // single beat: visible one cycle after the write, then read away
    cycle(1'b1, {{30{8'hA5}}, 30'h3FFFFFFF, 1'b1}, 1'b1);
    check("single_beat", {m_if.tdata, m_if.tkeep, m_if.tlast}, {{30{8'hA5}}, 30'h3FFFFFFF, 1'b1});
    cycle(1'b0, '0, 1'b1);

    // 40 incrementing beats, random consumer readiness, writer honours tready
    sent = 0;
    for (int c = 0; c < 400 && (sent < 40 || exp_q.size() != 0); c++) begin
      wv = (sent < 40) && (exp_q.size() < DEPTH);
      cycle(wv, mk(DWIDTH'(sent + 1)), 1'($urandom_range(0, 1)));
      if (wv) sent++;
    end
    check("stream_sent",  W'(sent),         W'(40));
    check("stream_empty", W'(exp_q.size()), W'(0));
    check("stream_no_ovf", W'(overflow),    W'(0));

    // pause hysteresis: on at 10, held at 6 and 5, off one edge after reaching 5
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(DWIDTH'(100 + i)), 1'b0);
    check("pause_at10_pre", W'(pause_req), W'(0));
    cycle(1'b0, '0, 1'b0);
    check("pause_at10_post", W'(pause_req), W'(1));
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    check("pause_at6", W'(pause_req), W'(1));
    cycle(1'b0, '0, 1'b1);
    check("pause_at5_pre", W'(pause_req), W'(1));
    cycle(1'b0, '0, 1'b0);
    check("pause_at5_post", W'(pause_req), W'(0));
    check("pause_dbg",      W'(dbg_paused), W'(0));
    drain();

    // overflow: fill to 16, three writes while full (read on the last one)
    for (int i = 0; i < 16; i++) cycle(1'b1, mk(DWIDTH'(200 + i)), 1'b0);
    check("full_no_ovf", W'(overflow), W'(0));
    cycle(1'b1, mk(DWIDTH'(300)), 1'b0);
    cycle(1'b1, mk(DWIDTH'(301)), 1'b0);
    cycle(1'b1, mk(DWIDTH'(302)), 1'b1);
    check("ovf_set", W'(overflow), W'(1));
`ifdef RIFL_RX_BUF_DROP_CNT_EN
    check("drop_cnt3", W'(drop_cnt), W'(3));
`else
    check("drop_cnt0", W'(drop_cnt), W'(0));
`endif
    drain();
    check("ovf_sticky", W'(overflow), W'(1));

    // reset mid-operation at 12 entries with pause raised; reset beats concurrent write/read
    for (int i = 0; i < 12; i++) cycle(1'b1, mk(DWIDTH'(400 + i)), 1'b0);
    cycle(1'b0, '0, 1'b0);
    check("pre_rst_pause", W'(pause_req), W'(1));
    rst = 1'b1; s_if.tvalid = 1'b1; m_if.tready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_if.tvalid = 1'b0; m_if.tready = 1'b0;
    exp_q.delete();
    exp_drops = 0;
    check("mid_rst_cnt",      W'(fifo_cnt),    W'(0));
    check("mid_rst_pause",    W'(pause_req),   W'(0));
    check("mid_rst_m_tvalid", W'(m_if.tvalid), W'(0));
    check("mid_rst_overflow", W'(overflow),    W'(0));
    check("mid_rst_drop_cnt", W'(drop_cnt),    W'(0));

    // buffer works normally after reset
    cycle(1'b1, mk(DWIDTH'(7)), 1'b0);
    cycle(1'b0, '0, 1'b1);

`ifdef RIFL_RX_BUF_DROP_CNT_EN
    // saturation of the drop counter
    for (int i = 0; i < 16; i++) cycle(1'b1, mk(DWIDTH'(500 + i)), 1'b0);
    s_if.tvalid = 1'b1; m_if.tready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    check("drop_cnt_sat", W'(drop_cnt), W'(16'hFFFF));
    check("sat_overflow", W'(overflow), W'(1));
    check("sat_cnt",      W'(fifo_cnt), W'(16));
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
